// File: rtl/dispatch_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dispatch_router                                              |
// | Description : In-order dispatch buffer between the decoder and the ALU,    |
// |               Branch and LSU reservation stations. Decoded uops are queued |
// |               in a circular FIFO; the head entry is steered to the station |
// |               named by its FU type over a valid/ready handshake. Illegal   |
// |               (FU type 11) heads are dropped and reported; i_flush empties |
// |               the queue.                                                   |
// | Ports       : clk, reset (async, active-high)                              |
// |               i_flush                  - discard all queued uops           |
// |               i_valid/i_uop/i_futype   - decoder side, o_ready back        |
// |               o_{alu,br,lsu}_valid / i_{alu,br,lsu}_ready - RS handshakes  |
// |               o_uop                    - head uop, shared by all RS ports  |
// |               o_illegal                - 1-cycle pulse after illegal drop  |
// |               o_count                  - occupancy                         |
// |               o_stall_cycles           - blocked-head cycle counter        |
// | Config      : DISPATCH_PERF_EN - enables o_stall_cycles (else tied to 0)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dispatch_router #(
  parameter int DEPTH = 4,
  parameter int UOP_W = 63
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [UOP_W-1:0]         i_uop,
  input  logic [1:0]               i_futype,
  output logic                     o_ready,
  output logic                     o_alu_valid,
  input  logic                     i_alu_ready,
  output logic                     o_br_valid,
  input  logic                     i_br_ready,
  output logic                     o_lsu_valid,
  input  logic                     i_lsu_ready,
  output logic [UOP_W-1:0]         o_uop,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_stall_cycles
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_PTR_W  = c_ADDR_W + 1;
  localparam int c_ENT_W  = UOP_W + 2;

  localparam logic [1:0] c_FU_ALU = 2'b00;
  localparam logic [1:0] c_FU_BR  = 2'b01;
  localparam logic [1:0] c_FU_LSU = 2'b10;
  localparam logic [1:0] c_FU_ILL = 2'b11;

  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  // Each entry stores {futype, uop}
  logic [c_ENT_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic               r_illegal;

  logic               w_full;
  logic               w_empty;
  logic [c_ENT_W-1:0] w_head;
  logic [1:0]         w_head_fu;
  logic               w_head_live;
  logic               w_deq_rs;
  logic               w_deq_ill;
  logic               w_deq;
  logic               w_enq;

  assign w_full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                   (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_head    = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_head_fu = w_head[c_ENT_W-1 -: 2];

  // Flush gates every valid so no handshake can complete in a flush cycle
  assign w_head_live = !w_empty && !i_flush;

  assign o_alu_valid = w_head_live && (w_head_fu == c_FU_ALU);
  assign o_br_valid  = w_head_live && (w_head_fu == c_FU_BR);
  assign o_lsu_valid = w_head_live && (w_head_fu == c_FU_LSU);

  assign w_deq_rs  = (o_alu_valid && i_alu_ready) ||
                     (o_br_valid  && i_br_ready)  ||
                     (o_lsu_valid && i_lsu_ready);
  // An illegal head is dropped at the end of its first cycle at the head
  assign w_deq_ill = w_head_live && (w_head_fu == c_FU_ILL);
  assign w_deq     = w_deq_rs || w_deq_ill;

  // Ready depends only on state; a slot freed this cycle is not reusable
  // until the next one
  assign o_ready = !w_full;
  assign w_enq   = i_valid && !w_full && !i_flush;

  assign o_uop     = w_head[UOP_W-1:0];
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_illegal = r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_deq_ill;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enq) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {i_futype, i_uop};
    end
  end

`ifdef DISPATCH_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall_cycles;

  // A live legal head that its station did not take this cycle
  assign w_stall = w_head_live && (w_head_fu != c_FU_ILL) && !w_deq_rs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dispatch_router                                           |
// | Description : Self-checking bench for dispatch_router. A queue-based       |
// |               reference model predicts occupancy, steering, illegal pulses |
// |               and the stall counter; directed scenarios plus a randomized  |
// |               run compare the DUT against it.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dispatch_router;

  localparam int DEPTH = 4;
  localparam int UOP_W = 63;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_flush, i_valid;
  logic [UOP_W-1:0] i_uop;
  logic [1:0]       i_futype;
  logic             o_ready;
  logic             o_alu_valid, i_alu_ready;
  logic             o_br_valid, i_br_ready;
  logic             o_lsu_valid, i_lsu_ready;
  logic [UOP_W-1:0] o_uop;
  logic             o_illegal;
  logic [2:0]       o_count;
  logic [31:0]      o_stall_cycles;

  dispatch_router #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_uop(i_uop), .i_futype(i_futype), .o_ready(o_ready),
    .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .o_br_valid(o_br_valid), .i_br_ready(i_br_ready),
    .o_lsu_valid(o_lsu_valid), .i_lsu_ready(i_lsu_ready),
    .o_uop(o_uop), .o_illegal(o_illegal), .o_count(o_count),
    .o_stall_cycles(o_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       fu;
    logic [UOP_W-1:0] uop;
  } ent_t;

  ent_t        q[$];
  logic        m_illegal;
  logic [31:0] m_stall;
  int          n_vec = 0;
  int          n_fail = 0;
  int          n_enq = 0;

`ifdef DISPATCH_PERF_EN
  localparam logic [31:0] PERF_EXPECT = 32'd7;
`else
  localparam logic [31:0] PERF_EXPECT = 32'd0;
`endif

  function automatic logic [UOP_W-1:0] mk_uop(input logic [8:0] pc);
    logic [53:0] rest;
    rest = {$urandom, $urandom};
    return {pc, rest};
  endfunction

  // Expected valid for one station, given model state and current flush
  function automatic logic exp_valid(input logic [1:0] fu);
    return (q.size() > 0) && !i_flush && (q[0].fu == fu);
  endfunction

  task automatic set_idle();
    i_flush = 0; i_valid = 0; i_uop = '0; i_futype = 2'b00;
    i_alu_ready = 0; i_br_ready = 0; i_lsu_ready = 0;
  endtask

  task automatic model_clear();
    q.delete();
    m_illegal = 1'b0;
    m_stall   = '0;
  endtask

  // Advance one clock: decide from the current inputs what the buffer does,
  // then apply it to the queue model at the edge.
  task automatic step();
    int   n;
    logic fl, enq, deq, ill, stall, rdy;
    ent_t e;
    n = q.size(); fl = i_flush;
    enq = i_valid && (n < DEPTH);
    deq = 0; ill = 0; stall = 0;
    if (n > 0 && !fl) begin
      case (q[0].fu)
        2'b00:   rdy = i_alu_ready;
        2'b01:   rdy = i_br_ready;
        2'b10:   rdy = i_lsu_ready;
        default: rdy = 1'b1;
      endcase
      deq   = rdy;
      ill   = (q[0].fu == 2'b11);
      stall = !ill && !rdy;
    end
    e.fu = i_futype; e.uop = i_uop;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (enq) begin q.push_back(e); n_enq++; end
    end
    m_illegal = ill;
`ifdef DISPATCH_PERF_EN
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`else
    stall = stall;
`endif
    #1;
  endtask

  task automatic push(input logic [1:0] fu, input logic [8:0] pc);
    i_valid = 1; i_futype = fu; i_uop = mk_uop(pc);
    step();
    i_valid = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    n_vec++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_vec++; if ({o_alu_valid, o_br_valid, o_lsu_valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_valids: got %b expected 000", {o_alu_valid, o_br_valid, o_lsu_valid}); end
    n_vec++; if (o_illegal !== 1'b0 || o_stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL reset_ill_stall: got %b/%0d expected 0/0", o_illegal, o_stall_cycles); end
    n_vec++; if (o_uop !== '0) begin n_fail++; $display("FAIL reset_uop: got %h expected 0", o_uop); end
  endtask

  task automatic test_single_alu();
    i_alu_ready = 1;
    i_valid = 1; i_futype = 2'b00; i_uop = mk_uop(9'h100);
    #1;
    n_vec++; if (o_alu_valid !== 1'b0) begin n_fail++; $display("FAIL alu_no_bypass: got %b expected 0", o_alu_valid); end
    step();
    i_valid = 0; #1;
    n_vec++; if (o_alu_valid !== 1'b1 || o_uop[62:54] !== 9'h100) begin n_fail++;
      $display("FAIL alu_offer: got valid=%b pc=%h expected valid=1 pc=100", o_alu_valid, o_uop[62:54]); end
    n_vec++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL alu_count1: got %0d expected 1", o_count); end
    step(); #1;
    n_vec++; if (o_count !== 3'(q.size()) || o_count !== 3'd0) begin n_fail++;
      $display("FAIL alu_drained: got %0d expected 0", o_count); end
    set_idle();
  endtask

  task automatic test_full();
    logic [UOP_W-1:0] first;
    for (int i = 0; i < 4; i++) push(2'b00, 9'(9'h20 + i));
    first = q[0].uop;
    #1;
    n_vec++; if (o_count !== 3'd4 || o_ready !== 1'b0) begin n_fail++;
      $display("FAIL full_state: got count=%0d ready=%b expected 4/0", o_count, o_ready); end
    push(2'b00, 9'h1FF);
    #1;
    n_vec++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_drop5: got %0d expected 4", o_count); end
    n_vec++; if (o_uop !== first) begin n_fail++; $display("FAIL full_head: got %h expected %h", o_uop, first); end
    // Dequeue while full: ready must stay low in that cycle
    i_alu_ready = 1; #1;
    n_vec++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_deq_ready: got %b expected 0", o_ready); end
    step(); #1;
    n_vec++; if (o_ready !== 1'b1 || o_count !== 3'd3) begin n_fail++;
      $display("FAIL full_after_deq: got ready=%b count=%0d expected 1/3", o_ready, o_count); end
    i_flush = 1; step(); set_idle();
  endtask

  task automatic test_order();
    logic [8:0] pcs [3];
    pcs[0] = 9'h0B1; pcs[1] = 9'h0C2; pcs[2] = 9'h0A3;
    i_alu_ready = 1;
    push(2'b01, pcs[0]); push(2'b10, pcs[1]); push(2'b00, pcs[2]);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (o_br_valid !== 1'b1 || o_alu_valid !== 1'b0 || o_count !== 3'd3) begin n_fail++;
        $display("FAIL order_block: got br=%b alu=%b count=%0d expected 1/0/3", o_br_valid, o_alu_valid, o_count); end
      step();
    end
    i_br_ready = 1; i_lsu_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (o_uop[62:54] !== pcs[k] || o_uop !== q[0].uop) begin n_fail++;
        $display("FAIL order_seq%0d: got pc=%h expected pc=%h", k, o_uop[62:54], pcs[k]); end
      step();
    end
    #1;
    n_vec++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL order_empty: got %0d expected 0", o_count); end
    set_idle();
  endtask

  task automatic test_illegal();
    push(2'b11, 9'h0EE);
    i_valid = 1; i_futype = 2'b00; i_uop = mk_uop(9'h0AA); #1;
    n_vec++; if ({o_alu_valid, o_br_valid, o_lsu_valid} !== 3'b000 || o_illegal !== 1'b0) begin n_fail++;
      $display("FAIL ill_head: got valids=%b ill=%b expected 000/0", {o_alu_valid, o_br_valid, o_lsu_valid}, o_illegal); end
    step(); i_valid = 0; #1;
    n_vec++; if (o_illegal !== 1'b1 || o_alu_valid !== 1'b1 || o_uop[62:54] !== 9'h0AA) begin n_fail++;
      $display("FAIL ill_pulse: got ill=%b alu=%b pc=%h expected 1/1/0aa", o_illegal, o_alu_valid, o_uop[62:54]); end
    step(); #1;
    n_vec++; if (o_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_once: got %b expected 0", o_illegal); end
    i_alu_ready = 1; step(); #1;
    n_vec++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL ill_drain: got %0d expected 0", o_count); end
    set_idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(2'b10, 9'(9'h40 + i));
    i_flush = 1; i_valid = 1; i_futype = 2'b10; i_uop = mk_uop(9'h55); i_lsu_ready = 1; #1;
    n_vec++; if (o_lsu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gate: got %b expected 0", o_lsu_valid); end
    step(); set_idle(); #1;
    n_vec++; if (o_count !== 3'd0 || o_ready !== 1'b1 || o_lsu_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_clear: got count=%0d ready=%b lsu=%b expected 0/1/0", o_count, o_ready, o_lsu_valid); end
    step(); #1;
    n_vec++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL flush_drop: got %0d expected 0", o_count); end
  endtask

  task automatic test_perf();
    do_reset();
    push(2'b10, 9'h077);
    repeat (7) step();
    i_lsu_ready = 1; step(); set_idle(); #1;
    n_vec++; if (o_stall_cycles !== PERF_EXPECT || o_stall_cycles !== m_stall) begin n_fail++;
      $display("FAIL perf_stall: got %0d expected %0d", o_stall_cycles, PERF_EXPECT); end
  endtask

  task automatic test_reset_mid();
    push(2'b00, 9'h011); push(2'b01, 9'h022);
    #1;
    reset = 1; #1;
    n_vec++; if (o_count !== 3'd0 || o_alu_valid !== 1'b0 || o_ready !== 1'b1 || o_stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL reset_mid: got count=%0d alu=%b ready=%b stall=%0d expected 0/0/1/0", o_count, o_alu_valid, o_ready, o_stall_cycles); end
    @(posedge clk); #1;
    reset = 0; model_clear();
  endtask

  task automatic test_random();
    logic [2:0] ev;
    int         start_enq;
    start_enq = n_enq;
    for (int c = 0; c < 3000; c++) begin
      i_flush     = ($urandom_range(0, 99) < 2);
      i_valid     = ($urandom_range(0, 99) < 70);
      i_futype    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      i_uop       = mk_uop(9'($urandom));
      i_alu_ready = $urandom_range(0, 1) == 1;
      i_br_ready  = $urandom_range(0, 1) == 1;
      i_lsu_ready = $urandom_range(0, 1) == 1;
      #1;
      ev = {exp_valid(2'b00), exp_valid(2'b01), exp_valid(2'b10)};
      n_vec++;
      if (o_count !== 3'(q.size()) || o_ready !== (q.size() < DEPTH) ||
          {o_alu_valid, o_br_valid, o_lsu_valid} !== ev || o_illegal !== m_illegal ||
          o_stall_cycles !== m_stall || (q.size() > 0 && o_uop !== q[0].uop)) begin
        n_fail++;
        $display("FAIL rand_c%0d: got cnt=%0d rdy=%b v=%b ill=%b st=%0d uop=%h expected cnt=%0d rdy=%b v=%b ill=%b st=%0d",
                 c, o_count, o_ready, {o_alu_valid, o_br_valid, o_lsu_valid}, o_illegal, o_stall_cycles, o_uop,
                 q.size(), q.size() < DEPTH, ev, m_illegal, m_stall);
      end
      step();
    end
    set_idle();
    n_vec++; if (n_enq - start_enq < 2 * DEPTH) begin n_fail++;
      $display("FAIL rand_wraps: got %0d enqueues expected >= %0d", n_enq - start_enq, 2 * DEPTH); end
  endtask

  initial begin
    set_idle();
    reset = 1;
    model_clear();
    test_reset();
    test_single_alu();
    test_full();
    test_order();
    test_illegal();
    test_flush();
    test_perf();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
